// File: rtl/cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_adder_pipe
// Brief    : Pipelined carry-lookahead adder, one GROUP-bit CLA group per
//            stage, valid/ready streaming with global stall. Optional signed
//            overflow output enabled by macro CLA_ADDER_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CLA_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int S = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0 || GROUP < 1) begin : g_bad_width
        $error("cla_adder_pipe: WIDTH must be a positive multiple of GROUP");
    end

    // Returns {carry into group MSB, group carry out, group sum}, carries fully expanded.
    function automatic logic [GROUP+1:0] cla_group(input logic [GROUP-1:0] x,
                                                   input logic [GROUP-1:0] y,
                                                   input logic             ci);
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             t;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int i = 1; i <= GROUP; i++) begin
            t = ci;
            for (int m = 0; m < i; m++) t = t & p[m];
            c[i] = t;
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m < i; m++) t = t & p[m];
                c[i] = c[i] | t;
            end
        end
        return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    logic                        w_en;
    logic [S-1:0]                r_v;
    logic [S-1:0]                r_c;
    logic [S-1:0][WIDTH-1:0]     r_a;
    logic [S-1:0][WIDTH-1:0]     r_b;
    logic [S-1:0][WIDTH-1:0]     r_s;
    logic [S-1:0]                w_src_v;
    logic [S-1:0]                w_src_c;
    logic [S-1:0]                w_nxt_c;
    logic [S-1:0][WIDTH-1:0]     w_src_a;
    logic [S-1:0][WIDTH-1:0]     w_src_b;
    logic [S-1:0][WIDTH-1:0]     w_src_s;
    logic [S-1:0][WIDTH-1:0]     w_nxt_s;
    logic [S-1:0][GROUP+1:0]     w_grp;
    logic                        w_unused;

    assign out_valid = r_v[S-1];
    assign sum       = r_s[S-1];
    assign c_out     = r_c[S-1];
    assign in_ready  = !out_valid || out_ready;
    assign w_en      = in_ready;

    // Each stage sees the previous stage's skewed operands, partial sum and carry.
    always_comb begin
        w_src_v    = '0;
        w_src_c    = '0;
        w_src_a    = '0;
        w_src_b    = '0;
        w_src_s    = '0;
        w_src_v[0] = in_valid;
        w_src_c[0] = c_in;
        w_src_a[0] = a;
        w_src_b[0] = b;
        for (int k = 1; k < S; k++) begin
            w_src_v[k] = r_v[k-1];
            w_src_c[k] = r_c[k-1];
            w_src_a[k] = r_a[k-1];
            w_src_b[k] = r_b[k-1];
            w_src_s[k] = r_s[k-1];
        end
        w_grp   = '0;
        w_nxt_c = '0;
        w_nxt_s = '0;
        for (int k = 0; k < S; k++) begin
            w_grp[k]   = cla_group(w_src_a[k][k*GROUP +: GROUP],
                                   w_src_b[k][k*GROUP +: GROUP], w_src_c[k]);
            w_nxt_c[k] = w_grp[k][GROUP];
            w_nxt_s[k] = w_src_s[k];
            w_nxt_s[k][k*GROUP +: GROUP] = w_grp[k][GROUP-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            r_c <= '0;
            r_a <= '0;
            r_b <= '0;
            r_s <= '0;
        end else if (w_en) begin
            r_v <= w_src_v;
            r_c <= w_nxt_c;
            r_a <= w_src_a;
            r_b <= w_src_b;
            r_s <= w_nxt_s;
        end
    end

`ifdef CLA_ADDER_OVF_EN
    logic r_ovf;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= w_grp[S-1][GROUP+1] ^ w_grp[S-1][GROUP];
        end
    end
    assign ovf = r_ovf;
`endif

    // Consumed operand bits and unneeded MSB carries are intentionally left dangling.
    assign w_unused = ^{r_a, r_b, w_grp};

endmodule
`default_nettype wire
